// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial line in, received byte with done/error strobes and busy out
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] uart_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
  modport master (output rx, input uart_data, rx_done, frame_err, rx_busy);
  modport slave (input rx, output uart_data, rx_done, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 LSB-first UART receiver; clk, rst (async high), bus: rx in, uart_data/rx_done/frame_err/rx_busy out
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 9600
) (
  input logic clk,
  input logic rst,
  uart_rx_byte_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic rx_m, rx_s, rx_d, fall;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh, uart_data;
  logic rx_done, frame_err, rx_busy;
  assign fall = rx_d & ~rx_s;
  assign bus.uart_data = uart_data;
  assign bus.rx_done = rx_done;
  assign bus.frame_err = frame_err;
  assign bus.rx_busy = rx_busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rx_m, rx_s, rx_d} <= 3'b111;
    else {rx_m, rx_s, rx_d} <= {bus.rx, rx_m, rx_s};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      uart_data <= '0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          cnt <= '0;
          rx_busy <= 1'b1;
        end
        START: if (cnt == CW'(HALF - 1)) begin
          cnt <= '0;
          bit_cnt <= '0;
          state <= rx_s ? IDLE : DATA;
          rx_busy <= ~rx_s;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == CW'(BAUD_DIV - 1)) begin
          cnt <= '0;
          sh <= {rx_s, sh[7:1]};
          if (bit_cnt == 3'd7) state <= STOP;
          else bit_cnt <= bit_cnt + 3'd1;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == CW'(BAUD_DIV - 1)) begin
          cnt <= '0;
          state <= IDLE;
          rx_busy <= 1'b0;
          rx_done <= rx_s;
          frame_err <= ~rx_s;
          if (rx_s) uart_data <= sh;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed table-driven bench for uart_rx_byte at BAUD_DIV=16, HALF=8
module tb_uart_rx_byte;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, n_chk = 0, n_bad = 0;
  int n_err = 0, t_err = 0, t_fall = 0, t_rise = 0, t_drop = 0, n_busy = 0;
  int dq[$];
  logic [7:0] qd[$];
  logic prev_busy = 1'b0;
  typedef struct {
    logic [7:0] d;
    logic stop;
    int ex_done;
    int ex_err;
    logic [7:0] ex_data;
  } vec_t;
  vec_t tv[6];
  uart_rx_byte_if bus();
  uart_rx_byte #(.CLK_FREQ(1600), .BAUD(100)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bus.rx_done) begin
      dq.push_back(cyc);
      qd.push_back(bus.uart_data);
    end
    if (bus.frame_err) begin
      n_err = n_err + 1;
      t_err = cyc;
    end
    if (bus.rx_done && bus.frame_err) begin
      n_bad = n_bad + 1;
      $display("FAIL done_err_overlap: both strobes high at cycle %0d, required never together", cyc);
    end
    if (bus.rx_busy) n_busy = n_busy + 1;
    if (bus.rx_busy && !prev_busy) t_rise = cyc;
    if (!bus.rx_busy && prev_busy) t_drop = cyc;
    prev_busy = bus.rx_busy;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic clr();
    dq.delete();
    qd.delete();
    n_err = 0;
    n_busy = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    t_fall = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      idle(16);
    end
  endtask
  initial begin
    int f0;
    tv[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    tv[1] = '{8'h11, 1'b1, 1, 0, 8'h11};
    tv[2] = '{8'h5A, 1'b0, 0, 1, 8'h11};
    tv[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    tv[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    tv[5] = '{8'h80, 1'b0, 0, 1, 8'hFF};
    bus.rx = 1'b1;
    idle(3);
    chk("rst_data", bus.uart_data, 8'h00);
    chk("rst_done", bus.rx_done, 1'b0);
    chk("rst_err", bus.frame_err, 1'b0);
    chk("rst_busy", bus.rx_busy, 1'b0);
    rst = 1'b0;
    clr();
    idle(1000);
    chk("idle_done", dq.size(), 0);
    chk("idle_err", n_err, 0);
    chk("idle_busy", n_busy, 0);
    chk("idle_data", bus.uart_data, 8'h00);
    for (int v = 0; v < 6; v++) begin
      clr();
      send_frame(tv[v].d, tv[v].stop);
      bus.rx = 1'b1;
      idle(20);
      chk($sformatf("v%0d_ndone", v), dq.size(), tv[v].ex_done);
      chk($sformatf("v%0d_nerr", v), n_err, tv[v].ex_err);
      chk($sformatf("v%0d_data", v), bus.uart_data, tv[v].ex_data);
      if (tv[v].ex_done == 1 && dq.size() == 1) begin
        chk($sformatf("v%0d_lat", v), dq[0] - t_fall, 154);
        chk($sformatf("v%0d_qdata", v), qd[0], tv[v].ex_data);
      end
      if (tv[v].ex_err == 1) chk($sformatf("v%0d_errlat", v), t_err - t_fall, 154);
      chk($sformatf("v%0d_busylen", v), t_drop - t_rise, 152);
      chk($sformatf("v%0d_busyrise", v), t_rise - t_fall, 2);
    end
    clr();
    send_frame(8'h31, 1'b1);
    f0 = t_fall;
    send_frame(8'h32, 1'b1);
    send_frame(8'h33, 1'b1);
    idle(20);
    chk("b2b_n", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b_lat0", dq[0] - f0, 154);
      chk("b2b_gap1", dq[1] - dq[0], 160);
      chk("b2b_gap2", dq[2] - dq[1], 160);
      chk("b2b_d0", qd[0], 8'h31);
      chk("b2b_d1", qd[1], 8'h32);
      chk("b2b_d2", qd[2], 8'h33);
    end
    clr();
    t_fall = cyc + 1;
    bus.rx = 1'b0;
    idle(3);
    bus.rx = 1'b1;
    idle(30);
    chk("glitch_done", dq.size(), 0);
    chk("glitch_err", n_err, 0);
    chk("glitch_data", bus.uart_data, 8'h33);
    chk("glitch_rise", t_rise - t_fall, 2);
    chk("glitch_drop", t_drop - t_fall, 10);
    send_frame(8'h11, 1'b1);
    bus.rx = 1'b1;
    idle(20);
    clr();
    send_frame(8'h5A, 1'b0);
    idle(500);
    chk("break_err", n_err, 1);
    chk("break_done", dq.size(), 0);
    chk("break_data", bus.uart_data, 8'h11);
    chk("break_busy", bus.rx_busy, 1'b0);
    bus.rx = 1'b1;
    idle(40);
    chk("break_rel_err", n_err, 1);
    chk("break_rel_busy", bus.rx_busy, 1'b0);
    clr();
    bus.rx = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      bus.rx = i[0];
      idle(16);
    end
    bus.rx = 1'b0;
    idle(8);
    chk("mid_busy", bus.rx_busy, 1'b1);
    rst = 1'b1;
    bus.rx = 1'b1;
    #1;
    chk("mid_rst_data", bus.uart_data, 8'h00);
    chk("mid_rst_busy", bus.rx_busy, 1'b0);
    chk("mid_rst_done", bus.rx_done, 1'b0);
    chk("mid_rst_err", bus.frame_err, 1'b0);
    idle(3);
    rst = 1'b0;
    idle(20);
    clr();
    send_frame(8'hC3, 1'b1);
    idle(20);
    chk("post_rst_n", dq.size(), 1);
    if (dq.size() == 1) begin
      chk("post_rst_lat", dq[0] - t_fall, 154);
      chk("post_rst_d", qd[0], 8'hC3);
    end
    chk("post_rst_err", n_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
